// File: rtl/ram_loader_pkg.sv
// rtl/ram_loader_pkg.sv - shared state encoding for the stream-to-RAM loader
package ram_loader_pkg;

    // Loader FSM states; encoding is fixed so other blocks can decode it.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/ram_sync_model.sv
// rtl/ram_sync_model.sv - sync-write, async-read memory used for loader readback
module ram_sync_model #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port: one word per enabled rising edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - loads a counted burst of stream words into consecutive RAM addresses
module ram_loader
    import ram_loader_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [AW:0]      length,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             we,
    output logic [AW-1:0]    waddr,
    output logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done
);

    localparam logic [AW:0]   MAX_LEN   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_LEN   = (AW+1)'(1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ONE_ADDR  = AW'(1);

    state_t         state;
    logic [AW-1:0]  ptr;
    logic [AW:0]    remaining;

    // Pointer wraps explicitly so non-power-of-two depths stay in range.
    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + ONE_ADDR;
    endfunction

    assign in_ready = (state == LOAD);
    assign busy     = (state != IDLE);

    // Loader FSM with pointer/count bookkeeping and registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            we        <= 1'b0;
            waddr     <= '0;
            wdata     <= '0;
            done      <= 1'b0;
        end else begin
            we   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr       <= base_addr;
                        remaining <= (length > MAX_LEN) ? MAX_LEN : length;
                        if (length == '0) begin
                            // Empty load still signals completion, one cycle later.
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        we        <= 1'b1;
                        waddr     <= ptr;
                        wdata     <= in_data;
                        ptr       <= next_ptr(ptr);
                        remaining <= remaining - ONE_LEN;
                        if (remaining == ONE_LEN) begin
                            // Last write and done land in the same FINISH cycle.
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - scoreboard bench for ram_loader with memory readback
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [8:0] length;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       we;
    logic [7:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] raddr;
    logic [7:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    ram_loader #(.WIDTH(8), .DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
    );

    ram_sync_model #(.WIDTH(8), .DEPTH(256)) mem (
        .clk(clk), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor: every we must match the oldest expected beat.
    always @(negedge clk) begin
        logic [15:0] e;
        if (done === 1'b1) done_cnt++;
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_we", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("waddr", {24'd0, waddr}, {24'd0, e[15:8]});
                check("wdata", {24'd0, wdata}, {24'd0, e[7:0]});
            end
        end
    end

    function automatic bit valid_pattern(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 4 == 0) || (cyc % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_we"},    {31'd0, we},       32'd0);
        check({tag, "_waddr"}, {24'd0, waddr},    32'd0);
        check({tag, "_wdata"}, {24'd0, wdata},    32'd0);
        check({tag, "_busy"},  {31'd0, busy},     32'd0);
        check({tag, "_done"},  {31'd0, done},     32'd0);
    endtask

    task automatic run_load(input logic [7:0] base, input logic [8:0] len,
                            input logic [7:0] d0, input int mode, input bit restart);
        int  rem;
        int  ptr;
        int  k;
        int  cyc;
        int  dn0;
        bit  v;
        bit  prev;
        rem = (len > 9'd256) ? 256 : int'(len);
        ptr = int'(base);
        k   = 0;
        dn0 = done_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; length = len; in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
        if (rem == 0) begin
            check("zl_done",  {31'd0, done},     32'd1);
            check("zl_we",    {31'd0, we},       32'd0);
            check("zl_ready", {31'd0, in_ready}, 32'd0);
        end else begin
            prev = 1'b0;
            cyc  = 0;
            while (rem > 0 && cyc < 2000) begin
                check("ready_load", {31'd0, in_ready}, 32'd1);
                check("we_latency", {31'd0, we},       {31'd0, prev});
                check("done_early", {31'd0, done},     32'd0);
                v = valid_pattern(mode, cyc);
                if (restart && cyc == 1) begin
                    start = 1'b1; base_addr = base + 8'h33; length = 9'd2;
                end else begin
                    start = 1'b0;
                end
                in_valid = v;
                in_data  = d0 + 8'(k);
                if (v) begin
                    exp_q.push_back({8'(ptr), d0 + 8'(k)});
                    ptr = (ptr + 1) % 256;
                    rem--;
                    k++;
                end
                prev = v;
                cyc++;
                @(posedge clk); #1;
            end
            if (cyc >= 2000) check("load_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            start    = 1'b0;
            check("final_we",     {31'd0, we},       32'd1);
            check("done_pulse",   {31'd0, done},     32'd1);
            check("busy_finish",  {31'd0, busy},     32'd1);
            check("ready_finish", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        check("done_clear", {31'd0, done},     32'd0);
        check("busy_idle",  {31'd0, busy},     32'd0);
        check("we_idle",    {31'd0, we},       32'd0);
        check("ready_idle", {31'd0, in_ready}, 32'd0);
        check("done_count", 32'(done_cnt - dn0), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_reset_abort();
        int dn0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 8'h40; length = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'hC0 + 8'(k);
            exp_q.push_back({8'h40 + 8'(k), 8'hC0 + 8'(k)});
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        dn0 = done_cnt;
        rst = 1'b1;
        #1;
        check_outputs_zero("abort_async");
        in_valid = 1'b1;
        in_data  = 8'h77;
        @(posedge clk); #1;
        check_outputs_zero("abort_edge");
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_we",    {31'd0, we},       32'd0);
            check("abort_no_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        check("abort_no_done", 32'(done_cnt - dn0), 32'd0);
        check("abort_queue",   32'(exp_q.size()),   32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0;
        in_valid = 1'b0; in_data = '0; raddr = '0;
        #3;
        check_outputs_zero("reset_async");
        @(posedge clk); @(posedge clk); #1;
        check_outputs_zero("reset_hold");
        rst = 1'b0;
        @(posedge clk); #1;
        check_outputs_zero("reset_release");

        // Basic back-to-back burst, then readback through the memory model.
        run_load(8'h10, 9'd4, 8'hA0, 0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            raddr = 8'h10 + 8'(i);
            #1;
            check("basic_readback", {24'd0, rdata}, {24'd0, 8'hA0 + 8'(i)});
        end

        run_load(8'hFE, 9'd4, 8'h50, 0, 1'b0);
        run_load(8'h20, 9'd0, 8'h00, 0, 1'b0);
        run_load(8'h30, 9'd4, 8'h60, 1, 1'b1);
        run_load(8'h80, 9'h1FF, 8'h11, 2, 1'b0);
        run_reset_abort();

        run_load(8'h00, 9'd256, 8'h00, 0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            raddr = 8'(i);
            #1;
            check("fill_readback", {24'd0, rdata}, 32'(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, target memory depth in words; AW = $clog2(DEPTH).
REQ-003 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1, one-cycle load request.
REQ-006 SHALL have port base_addr, input, AW, first write address, sampled with start.
REQ-007 SHALL have port length, input, AW+1, words to write (0..DEPTH), sampled with start.
REQ-008 SHALL have port in_valid, input, 1, stream word valid.
REQ-009 SHALL have port in_data, input, WIDTH, stream word.
REQ-010 SHALL have port in_ready, output, 1, loader accepts word.
REQ-011 SHALL have port we, output, 1, memory write enable.
REQ-012 SHALL have port waddr, output, AW, memory write address.
REQ-013 SHALL have port wdata, output, WIDTH, memory write data.
REQ-014 SHALL have port busy, output, 1, high while load in progress.
REQ-015 SHALL have port done, output, 1, one-cycle pulse at load completion.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD, FINISH.
REQ-017 IDLE: start=1 SHALL capture base_addr into pointer, length into remaining count; next state LOAD if length!=0, else FINISH.
REQ-018 LOAD: in_ready SHALL be 1 combinationally; in_ready SHALL be 0 in IDLE and FINISH.
REQ-019 Beat accepted when in_valid&&in_ready; SHALL register we=1, waddr=pointer, wdata=in_data in the next cycle (latency 1).
REQ-020 we SHALL be 0 in every cycle following a cycle with no accepted beat.
REQ-021 Each accepted beat SHALL increment pointer modulo DEPTH (DEPTH-1 wraps to 0) and decrement remaining by 1.
REQ-022 Beat that drops remaining to 0 SHALL transition LOAD->FINISH in the same edge.
REQ-023 FINISH SHALL last exactly one cycle with done=1, then return to IDLE; the final we and done coincide in this cycle.
REQ-024 busy SHALL be 1 in LOAD and FINISH, 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored; no capture, no state change.
REQ-026 length values above DEPTH SHALL be saturated to DEPTH.
REQ-027 in_valid gaps SHALL stall without state change; no timeout.
REQ-028 waddr/wdata SHALL hold last values when we=0.

Reset
REQ-029 rst=1 SHALL asynchronously force state IDLE, pointer 0, remaining 0.
REQ-030 During/after reset: in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0.
REQ-031 Reset mid-load SHALL abort without done pulse; no further writes.

Structure
REQ-032 State encoding (IDLE=2'd0, LOAD=2'd1, FINISH=2'd2) SHALL live in shared package ram_loader_pkg.
REQ-033 No RTL sub-module; single FSM plus pointer/counter/output registers.
REQ-034 Bench SHALL pair ram_loader with a sync-write, async-read memory model ram_sync_model of same WIDTH/DEPTH for readback.

Verification
REQ-035 Reset: rst pulse mid-LOAD -> all outputs 0 next edge, no done, state IDLE.
REQ-036 Basic: base_addr=0x10, length=4, data A0,A1,A2,A3 back-to-back -> we at addr 0x10..0x13 on 4 consecutive cycles, done with last write, busy falls next cycle.
REQ-037 Wrap: DEPTH=256, base_addr=0xFE, length=4 -> writes to 0xFE,0xFF,0x00,0x01.
REQ-038 Zero length: start with length=0 -> no we, done=1 one cycle after start, in_ready never 1.
REQ-039 Stall and ignored start: in_valid toggled 1,0,0,1 with start re-pulsed during LOAD -> exactly length writes, contiguous addresses, original base kept.
REQ-040 Full fill: base_addr=0, length=256, counting data -> readback memory[i]==i for all i, single done pulse.
